// File: rtl/jukebox_sample_player.sv
// Jukebox sample player: ROM sample fetch on 22 kHz ticks plus PWM DAC.
// Playback control with start/stop/pause/loop and overrun detection.
module jukebox_sample_player #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk_27MHz,
   input  logic              reset,
   input  logic              clk_22KHz,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop,
   input  logic [ADDR_W-1:0] song_start,
   input  logic [ADDR_W-1:0] song_end,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_vld,
   output logic              pwm_out,
   output logic              playing,
   output logic              done,
   output logic              overrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_READ,
      S_LATCH,
      S_PAUSED
   } state_t;

   localparam logic [DATA_W-1:0] MID_LEVEL = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic s3_q, s3_d;
   logic tick;

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              rom_rd_q, rom_rd_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic              sample_vld_q, sample_vld_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic              pwm_q, pwm_d;
   logic              busy;

   // Synchronise the sample-rate clock and detect its rising edge.
   always_comb begin
      s1_d = clk_22KHz;
      s2_d = s1_q;
      s3_d = s2_q;
      tick = s2_q & ~s3_q;
   end

   assign busy = (state_q == S_READ) || (state_q == S_LATCH);

   // Playback FSM: command priority stop > start > pause > tick.
   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      start_d      = start_q;
      end_d        = end_q;
      rom_rd_d     = 1'b0;
      sample_d     = sample_q;
      sample_vld_d = 1'b0;
      done_d       = 1'b0;
      overrun_d    = overrun_q | (tick & busy);
      if (stop) begin
         state_d  = S_IDLE;
         sample_d = MID_LEVEL;
      end else if (start) begin
         start_d    = song_start;
         end_d      = song_end;
         rom_addr_d = song_start;
         overrun_d  = 1'b0;
         state_d    = S_RUN;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_RUN: begin
               if (pause) begin
                  state_d = S_PAUSED;
               end else if (tick) begin
                  rom_rd_d = 1'b1;
                  state_d  = S_READ;
               end
            end
            S_READ: begin
               state_d = S_LATCH;
            end
            S_LATCH: begin
               sample_d     = rom_data;
               sample_vld_d = 1'b1;
               state_d      = S_RUN;
               if (rom_addr_q == end_q) begin
                  if (loop) begin
                     rom_addr_d = start_q;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_ONE;
               end
            end
            S_PAUSED: begin
               if (pause) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Free-running PWM counter and registered comparator output.
   always_comb begin
      cnt_d = cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
      pwm_d = (cnt_q < sample_q);
   end

   // State and datapath registers.
   always_ff @(posedge clk_27MHz or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         rom_addr_q   <= '0;
         start_q      <= '0;
         end_q        <= '0;
         rom_rd_q     <= 1'b0;
         sample_q     <= MID_LEVEL;
         sample_vld_q <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         cnt_q        <= '0;
         pwm_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         rom_addr_q   <= rom_addr_d;
         start_q      <= start_d;
         end_q        <= end_d;
         rom_rd_q     <= rom_rd_d;
         sample_q     <= sample_d;
         sample_vld_q <= sample_vld_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         cnt_q        <= cnt_d;
         pwm_q        <= pwm_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign rom_rd     = rom_rd_q;
   assign sample     = sample_q;
   assign sample_vld = sample_vld_q;
   assign pwm_out    = pwm_q;
   assign done       = done_q;
   assign overrun    = overrun_q;
   assign playing    = (state_q == S_RUN) || busy;

endmodule

// File: tb/tb_jukebox_sample_player.sv
// Testbench for jukebox_sample_player.
// Vector table of songs plus directed pause/stop/reset/overrun/PWM sequences.
module tb_jukebox_sample_player;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk22 = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic        loop = 1'b0;
   logic [15:0] song_start = '0;
   logic [15:0] song_end = '0;
   logic [15:0] rom_addr;
   logic        rom_rd;
   logic [7:0]  rom_data = '0;
   logic [7:0]  sample;
   logic        sample_vld;
   logic        pwm_out;
   logic        playing;
   logic        done;
   logic        overrun;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int rd_cnt = 0;

   typedef struct {
      logic [15:0]       st;
      logic [15:0]       en;
      logic              lp;
      int                nt;
      logic [0:5][7:0]   exp;
      logic [0:5]        vld;
      int                ndone;
   } vec_t;

   vec_t vecs[5];

   jukebox_sample_player dut (
      .clk_27MHz (clk),
      .reset     (reset),
      .clk_22KHz (clk22),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .loop      (loop),
      .song_start(song_start),
      .song_end  (song_end),
      .rom_addr  (rom_addr),
      .rom_rd    (rom_rd),
      .rom_data  (rom_data),
      .sample    (sample),
      .sample_vld(sample_vld),
      .pwm_out   (pwm_out),
      .playing   (playing),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // ROM model: ROM[a] = a[7:0], one-cycle read latency.
   always @(posedge clk) begin
      if (rom_rd) rom_data <= rom_addr[7:0];
   end

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rom_rd) rd_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_song(input logic [15:0] st, input logic [15:0] en);
      @(negedge clk);
      song_start = st;
      song_end = en;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      song_start = 16'hAAAA;
      song_end = 16'h5555;
   endtask

   task automatic pulse_pause();
      @(negedge clk);
      pause = 1'b1;
      @(negedge clk);
      pause = 1'b0;
   endtask

   // One sample-clock pulse; sample expected 5 cycles after its rise.
   task automatic do_tick(input logic [7:0] exp, input logic exp_vld,
                          input string nm);
      @(negedge clk);
      clk22 = 1'b1;
      @(negedge clk);
      clk22 = 1'b0;
      repeat (3) @(negedge clk);
      chk({nm, "_vld_early"}, sample_vld, 1'b0);
      @(negedge clk);
      chk({nm, "_vld"}, sample_vld, exp_vld);
      chk({nm, "_sample"}, sample, exp);
      repeat (3) @(negedge clk);
   endtask

   task automatic pwm_count(input int exp, input string nm);
      int hi;
      hi = 0;
      for (int k = 0; k < 512; k++) begin
         @(negedge clk);
         if (pwm_out) hi++;
      end
      chk(nm, hi, exp);
   endtask

   initial begin
      int d0;
      int r0;
      vecs[0] = '{16'h0010, 16'h0012, 1'b0, 4,
                  {8'h10, 8'h11, 8'h12, 8'h12, 8'h00, 8'h00}, 6'b111000, 1};
      vecs[1] = '{16'h0010, 16'h0012, 1'b1, 5,
                  {8'h10, 8'h11, 8'h12, 8'h10, 8'h11, 8'h00}, 6'b111110, 0};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 4,
                  {8'hFF, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00}, 6'b111000, 1};
      vecs[3] = '{16'h0020, 16'h0020, 1'b1, 3,
                  {8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00}, 6'b111000, 0};
      vecs[4] = '{16'h0030, 16'h0030, 1'b0, 2,
                  {8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b100000, 1};

      do_reset();
      chk("rst_addr", rom_addr, 16'h0);
      chk("rst_rd", rom_rd, 1'b0);
      chk("rst_sample", sample, 8'h80);
      chk("rst_vld", sample_vld, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_play", playing, 1'b0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         loop = vecs[i].lp;
         start_song(vecs[i].st, vecs[i].en);
         chk($sformatf("v%0d_play", i), playing, 1'b1);
         d0 = done_cnt;
         for (int k = 0; k < vecs[i].nt; k++) begin
            do_tick(vecs[i].exp[k], vecs[i].vld[k],
                    $sformatf("v%0d_t%0d", i, k));
         end
         chk($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].ndone);
         chk($sformatf("v%0d_ovr", i), overrun, 1'b0);
      end
      loop = 1'b0;

      // pause holds the sample and suppresses reads
      do_reset();
      start_song(16'h0010, 16'h0012);
      do_tick(8'h10, 1'b1, "ps_first");
      pulse_pause();
      chk("ps_play", playing, 1'b0);
      r0 = rd_cnt;
      for (int k = 0; k < 3; k++) do_tick(8'h10, 1'b0, "ps_held");
      chk("ps_no_rd", rd_cnt - r0, 0);
      pulse_pause();
      do_tick(8'h11, 1'b1, "ps_resume");
      chk("ps_ovr", overrun, 1'b0);

      // stop beats a simultaneous start
      do_reset();
      start_song(16'h0010, 16'h0012);
      do_tick(8'h10, 1'b1, "ss_first");
      d0 = done_cnt;
      @(negedge clk);
      stop = 1'b1;
      start = 1'b1;
      song_start = 16'h0050;
      song_end = 16'h0052;
      @(negedge clk);
      stop = 1'b0;
      start = 1'b0;
      chk("ss_play", playing, 1'b0);
      chk("ss_sample", sample, 8'h80);
      do_tick(8'h80, 1'b0, "ss_idle");
      chk("ss_done", done_cnt - d0, 0);

      // reset asserted while a read is in flight
      do_reset();
      start_song(16'h0010, 16'h0012);
      do_tick(8'h10, 1'b1, "rm_first");
      @(negedge clk);
      clk22 = 1'b1;
      @(negedge clk);
      clk22 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rm_in_read", rom_rd, 1'b1);
      reset = 1'b1;
      #1;
      chk("rm_rd", rom_rd, 1'b0);
      chk("rm_sample", sample, 8'h80);
      chk("rm_addr", rom_addr, 16'h0);
      chk("rm_play", playing, 1'b0);
      chk("rm_vld", sample_vld, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      do_tick(8'h80, 1'b0, "rm_idle");

      // second tick during READ/LATCH sets sticky overrun
      do_reset();
      start_song(16'h0010, 16'h0012);
      @(negedge clk);
      clk22 = 1'b1;
      @(negedge clk);
      clk22 = 1'b0;
      @(negedge clk);
      clk22 = 1'b1;
      @(negedge clk);
      clk22 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ov_set", overrun, 1'b1);
      chk("ov_sample", sample, 8'h10);
      repeat (5) @(negedge clk);
      chk("ov_sticky", overrun, 1'b1);
      start_song(16'h0010, 16'h0012);
      chk("ov_clear", overrun, 1'b0);

      // PWM duty
      do_reset();
      start_song(16'h0040, 16'h0040);
      do_tick(8'h40, 1'b1, "pw40");
      pwm_count(128, "pwm_40");
      do_reset();
      pwm_count(256, "pwm_80");
      start_song(16'h0100, 16'h0100);
      do_tick(8'h00, 1'b1, "pw00");
      pwm_count(0, "pwm_00");
      start_song(16'h00FF, 16'h00FF);
      do_tick(8'hFF, 1'b1, "pwff");
      pwm_count(510, "pwm_ff");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
